// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// width codes, FSM state encoding and byte-enable patterns.
package dmem_access_ctrl_pkg;

  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/dmem_access_ctrl_lane_steer.sv
// Byte-lane steering for stores and field extraction for loads.
// Purely combinational; also flags misaligned or illegal widths.
module mem_lane_steer
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  whb,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ld_unsigned,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ld_ext,
  output logic        misalign
);

  logic [31:0] r;
  logic        sx;

  always_comb begin
    r          = rdata >> {off, 3'b000};
    sx         = ~ld_unsigned;
    be         = '0;
    lane_wdata = '0;
    ld_ext     = r;
    misalign   = 1'b0;
    unique case (whb)
      WHB_BYTE: begin
        be         = BE_BYTE << off;
        lane_wdata = {4{wdata[7:0]}};
        ld_ext     = {{24{sx & r[7]}}, r[7:0]};
      end
      WHB_HALF: begin
        be         = off[1] ? BE_HALF_HI : BE_HALF_LO;
        lane_wdata = {2{wdata[15:0]}};
        ld_ext     = {{16{sx & r[15]}}, r[15:0]};
        misalign   = off[0];
      end
      WHB_WORD: begin
        be         = BE_WORD;
        lane_wdata = wdata;
        ld_ext     = r;
        misalign   = |off;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack handshake,
// pipeline stall, load extension, misalign and timeout reporting.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_whb,
  input  logic        mem_ld_unsigned,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t      state, state_nx;
  logic [1:0]  r_off;
  logic [1:0]  r_whb;
  logic        r_uns;
  logic [CW-1:0] tmo_cnt;

  logic        in_wait;
  logic [1:0]  s_off;
  logic [1:0]  s_whb;
  logic        s_uns;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic [31:0] s_ld;
  logic        s_mis;

  logic start, go_exc, ack_hit, tmo_hit, tmo_now;

  // In WAIT the steering unit extracts with the latched access fields
  assign in_wait = (state == ST_WAIT);
  assign s_off   = in_wait ? r_off : mem_addr[1:0];
  assign s_whb   = in_wait ? r_whb : mem_whb;
  assign s_uns   = in_wait ? r_uns : mem_ld_unsigned;

  mem_lane_steer u_steer (
    .off         (s_off),
    .whb         (s_whb),
    .wdata       (mem_wdata),
    .rdata       (dmem_rdata),
    .ld_unsigned (s_uns),
    .be          (s_be),
    .lane_wdata  (s_wdata),
    .ld_ext      (s_ld),
    .misalign    (s_mis)
  );

  assign tmo_now = (TIMEOUT_CYCLES != 0) &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    start    = 1'b0;
    go_exc   = 1'b0;
    ack_hit  = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          stall = 1'b1;
          if (s_mis) begin
            go_exc   = 1'b1;
            state_nx = ST_DONE;
          end else begin
            start    = 1'b1;
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          ack_hit  = 1'b1;
          state_nx = ST_DONE;
        end else if (tmo_now) begin
          tmo_hit  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      r_off        <= '0;
      r_whb        <= '0;
      r_uns        <= 1'b0;
      tmo_cnt      <= '0;
      ld_valid     <= 1'b0;
      ld_data      <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
    end else begin
      state        <= state_nx;
      ld_valid     <= ack_hit & ~dmem_we;
      misalign_exc <= go_exc;
      bus_err      <= tmo_hit;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_we;
        dmem_addr  <= {mem_addr[31:2], 2'b00};
        dmem_be    <= s_be;
        dmem_wdata <= s_wdata;
        r_off      <= mem_addr[1:0];
        r_whb      <= mem_whb;
        r_uns      <= mem_ld_unsigned;
        tmo_cnt    <= '0;
      end else if (ack_hit | tmo_hit) begin
        dmem_req   <= 1'b0;
        dmem_we    <= 1'b0;
        dmem_addr  <= '0;
        dmem_be    <= '0;
        dmem_wdata <= '0;
      end else if (in_wait) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (ack_hit & ~dmem_we)
        ld_data <= s_ld;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl against a
// byte-arithmetic reference model with randomized accesses.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_valid_to;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_whb;
  logic        mem_ld_unsigned;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  logic        stall, ld_valid, misalign_exc, bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] ld_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  logic        to_stall, to_ld_valid, to_misalign_exc, to_bus_err;
  logic        to_req, to_we;
  logic [31:0] to_ld_data, to_addr, to_wdata;
  logic [3:0]  to_be;

  int nerr = 0;
  int nchk = 0;
  logic [31:0] exp_ld;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_whb(mem_whb),
    .mem_ld_unsigned(mem_ld_unsigned), .stall(stall), .ld_valid(ld_valid),
    .ld_data(ld_data), .misalign_exc(misalign_exc), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) u_to (
    .clk(clk), .rst(rst), .mem_valid(mem_valid_to), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_whb(mem_whb),
    .mem_ld_unsigned(mem_ld_unsigned), .stall(to_stall),
    .ld_valid(to_ld_valid), .ld_data(to_ld_data),
    .misalign_exc(to_misalign_exc), .bus_err(to_bus_err),
    .dmem_req(to_req), .dmem_we(to_we), .dmem_addr(to_addr),
    .dmem_be(to_be), .dmem_wdata(to_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one access on u_dut; expectations come from byte arithmetic
  task automatic access(input string nm, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] whb, input logic uns,
                        input int dly, input logic [31:0] rd);
    logic bad;
    int nb, off, m;
    logic [3:0] ebe;
    logic [31:0] ewd, sh, mask, eld;
    off = int'(addr[1:0]);
    bad = (whb == 2'b11) || (whb == 2'b01 && addr[0]) ||
          (whb == 2'b10 && off != 0);
    nb  = (whb == 2'b00) ? 1 : (whb == 2'b01) ? 2 : 4;
    m   = ((1 << nb) - 1) << off;
    ebe = m[3:0];
    ewd = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    sh  = rd >> (8 * off);
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    eld = sh & mask;
    if (!uns && sh[8*nb-1]) eld = eld | ~mask;

    mem_valid = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    mem_whb = whb; mem_ld_unsigned = uns; dmem_ack = 1'b0;
    dmem_rdata = rd;
    @(negedge clk);
    nchk++;
    if ({stall, dmem_req, misalign_exc, ld_valid, bus_err} !== 5'b10000) begin
      nerr++;
      $display("FAIL %s issue flags got=%b want=10000", nm,
               {stall, dmem_req, misalign_exc, ld_valid, bus_err});
    end
    if (bad) begin
      @(negedge clk);
      nchk++;
      if ({stall, dmem_req, misalign_exc, ld_valid, bus_err, dmem_be} !==
          {5'b00100, 4'b0000}) begin
        nerr++;
        $display("FAIL %s exc flags got=%b want=001000000", nm,
                 {stall, dmem_req, misalign_exc, ld_valid, bus_err, dmem_be});
      end
    end else begin
      for (int c = 0; c <= dly; c++) begin
        @(posedge clk); #1;
        dmem_ack = (c == dly);
        dmem_rdata = (c == dly) ? rd : $urandom;
        @(negedge clk);
        nchk++;
        if ({stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
            {2'b11, we, addr & 32'hFFFF_FFFC, ebe, ewd}) begin
          nerr++;
          $display("FAIL %s wait%0d got s/r/we=%b a=%h be=%b wd=%h want we=%b a=%h be=%b wd=%h",
                   nm, c, {stall, dmem_req, dmem_we}, dmem_addr, dmem_be,
                   dmem_wdata, we, addr & 32'hFFFF_FFFC, ebe, ewd);
        end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      if (!we) exp_ld = eld;
      nchk++;
      if ({stall, dmem_req, misalign_exc, ld_valid, bus_err, ld_data} !==
          {3'b000, ~we, 1'b0, exp_ld}) begin
        nerr++;
        $display("FAIL %s done got flags=%b ld=%h want flags=%b ld=%h", nm,
                 {stall, dmem_req, misalign_exc, ld_valid, bus_err}, ld_data,
                 {3'b000, ~we, 1'b0}, exp_ld);
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_valid = 1'b0; mem_valid_to = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_whb = '0; mem_ld_unsigned = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0; exp_ld = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({stall, ld_valid, misalign_exc, bus_err, dmem_req, dmem_we, dmem_be,
         dmem_addr, dmem_wdata, ld_data, to_stall, to_req, to_bus_err} !== '0) begin
      nerr++;
      $display("FAIL reset outputs nonzero req=%b be=%b a=%h wd=%h ld=%h",
               dmem_req, dmem_be, dmem_addr, dmem_wdata, ld_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    access("sb_103", 1'b1, 32'h103, 32'h0000_00AB, 2'b00, 1'b0, 0, 32'h0);
    access("lh_202", 1'b0, 32'h202, 32'h0, 2'b01, 1'b0, 0, 32'h8001_1234);
    nchk++;
    if (ld_data !== 32'hFFFF_8001) begin
      nerr++;
      $display("FAIL lh_const got=%h want=ffff8001", ld_data);
    end
    access("lhu_202", 1'b0, 32'h202, 32'h0, 2'b01, 1'b1, 1, 32'h8001_1234);
    nchk++;
    if (ld_data !== 32'h0000_8001) begin
      nerr++;
      $display("FAIL lhu_const got=%h want=00008001", ld_data);
    end
  endtask

  task automatic test_misalign();
    access("lw_306", 1'b0, 32'h306, 32'h0, 2'b10, 1'b0, 0, 32'h0);
    access("sh_odd", 1'b1, 32'h401, 32'h1234, 2'b01, 1'b0, 0, 32'h0);
    access("w11_al", 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 0, 32'h0);
    access("w11_un", 1'b1, 32'h103, 32'h5A, 2'b11, 1'b0, 0, 32'h0);
  endtask

  task automatic test_sw_delay();
    access("sw_dly5", 1'b1, 32'h40C, 32'hDEAD_BEEF, 2'b10, 1'b0, 5, 32'h0);
  endtask

  task automatic test_timeout();
    mem_valid_to = 1'b1; mem_we = 1'b0; mem_addr = 32'h80;
    mem_whb = 2'b10; dmem_ack = 1'b0;
    @(negedge clk);
    nchk++;
    if ({to_stall, to_req} !== 2'b10) begin
      nerr++;
      $display("FAIL to_issue got=%b want=10", {to_stall, to_req});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nchk++;
      if ({to_stall, to_req, to_bus_err} !== 3'b110) begin
        nerr++;
        $display("FAIL to_wait%0d got=%b want=110", c,
                 {to_stall, to_req, to_bus_err});
      end
    end
    @(negedge clk);
    mem_valid_to = 1'b0;
    nchk++;
    if ({to_stall, to_req, to_bus_err, to_ld_valid} !== 4'b0010) begin
      nerr++;
      $display("FAIL to_done got=%b want=0010",
               {to_stall, to_req, to_bus_err, to_ld_valid});
    end
    @(negedge clk);
    nchk++;
    if ({to_stall, to_req, to_bus_err} !== 3'b000) begin
      nerr++;
      $display("FAIL to_idle got=%b want=000", {to_stall, to_req, to_bus_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious_ack();
    mem_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      nchk++;
      if ({stall, dmem_req, ld_valid, misalign_exc, bus_err, ld_data} !==
          {5'b00000, exp_ld}) begin
        nerr++;
        $display("FAIL spurious_ack got flags=%b ld=%h want ld=%h",
                 {stall, dmem_req, ld_valid, misalign_exc, bus_err},
                 ld_data, exp_ld);
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  task automatic test_rst_mid_wait();
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_whb = 2'b10;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    nchk++;
    if (dmem_req !== 1'b1) begin
      nerr++;
      $display("FAIL rst_pre_req got=%b want=1", dmem_req);
    end
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ld = '0;
    @(negedge clk);
    nchk++;
    if ({stall, ld_valid, misalign_exc, bus_err, dmem_req, dmem_we, dmem_be,
         dmem_addr, dmem_wdata, ld_data} !== '0) begin
      nerr++;
      $display("FAIL rst_mid_wait req=%b be=%b a=%h ld=%h want all 0",
               dmem_req, dmem_be, dmem_addr, ld_data);
    end
    @(posedge clk); #1;
    access("lb_after_rst", 1'b0, 32'h55, 32'h0, 2'b00, 1'b0, 0, 32'h1122_33C4);
  endtask

  task automatic test_back_to_back();
    access("b2b_sb", 1'b1, 32'h501, 32'h77, 2'b00, 1'b0, 0, 32'h0);
    access("b2b_lb", 1'b0, 32'h503, 32'h0, 2'b00, 1'b0, 0, 32'h9A00_0000);
    access("b2b_sh", 1'b1, 32'h502, 32'hBEEF, 2'b01, 1'b0, 2, 32'h0);
    access("b2b_lbu", 1'b0, 32'h503, 32'h0, 2'b00, 1'b1, 1, 32'h9A00_0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom,
             $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 6), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_sw_delay();
    test_timeout();
    test_spurious_ack();
    test_rst_mid_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
